// File: rtl/fp_mult_host.sv
// Host-side initiator for the fp_mult byte-serial core: core reset pulse, 16-byte operand stream, 8-byte result collection.
// Optional WAIT/RECV timeout abort with ERROR pulse is built when FP_MULT_HOST_TIMEOUT_EN is defined.
module fp_mult_host #(
  parameter int NBYTES_OP = 8
`ifdef FP_MULT_HOST_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [8*NBYTES_OP-1:0]   OP_A,
  input  logic [8*NBYTES_OP-1:0]   OP_B,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [8*NBYTES_OP-1:0]   RESULT,
`ifdef FP_MULT_HOST_TIMEOUT_EN
  output logic                     ERROR,
`endif
  output logic                     CORE_RESET,
  output logic                     ENABLE,
  output logic [7:0]               TX_DATA,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_READY
);

  localparam int RW = 8 * NBYTES_OP;
  localparam int OW = 16 * NBYTES_OP;

  typedef enum logic [2:0] {IDLE, CRST, SEND, WAIT, RECV} state_t;

  state_t          state_reg, state_next;
  logic [OW-1:0]   op_sr_reg, op_sr_next;
  logic [RW-1:0]   res_sr_reg, res_sr_next;
  logic [RW-1:0]   res_shift;
  logic [RW-1:0]   result_reg, result_next;
  logic [3:0]      txcnt_reg, txcnt_next;
  logic [3:0]      rxcnt_reg, rxcnt_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            core_reset_reg, core_reset_next;
  logic            enable_reg, enable_next;
  logic [7:0]      tx_data_reg, tx_data_next;
`ifdef FP_MULT_HOST_TIMEOUT_EN
  logic [15:0]     to_cnt_reg, to_cnt_next;
  logic            error_reg, error_next;
`endif

  always_comb begin
    state_next      = state_reg;
    op_sr_next      = op_sr_reg;
    res_sr_next     = res_sr_reg;
    result_next     = result_reg;
    txcnt_next      = txcnt_reg;
    rxcnt_next      = rxcnt_reg;
    busy_next       = busy_reg;
    done_next       = 1'b0;
    core_reset_next = 1'b0;
    enable_next     = 1'b0;
    tx_data_next    = 8'h00;
    res_shift       = {res_sr_reg[RW-9:0], RX_DATA};
`ifdef FP_MULT_HOST_TIMEOUT_EN
    to_cnt_next     = to_cnt_reg;
    error_next      = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (START) begin
          op_sr_next      = {OP_A, OP_B};
          busy_next       = 1'b1;
          core_reset_next = 1'b1;
          state_next      = CRST;
        end
      end
      CRST: begin
        // The first byte is loaded here so ENABLE runs gap-free from the next cycle.
        enable_next  = 1'b1;
        tx_data_next = op_sr_reg[OW-1 -: 8];
        op_sr_next   = {op_sr_reg[OW-9:0], 8'h00};
        txcnt_next   = 4'd0;
        state_next   = SEND;
      end
      SEND: begin
        if (txcnt_reg == 4'(2*NBYTES_OP-1)) begin
          state_next = WAIT;
`ifdef FP_MULT_HOST_TIMEOUT_EN
          to_cnt_next = 16'd0;
`endif
        end else begin
          enable_next  = 1'b1;
          tx_data_next = op_sr_reg[OW-1 -: 8];
          op_sr_next   = {op_sr_reg[OW-9:0], 8'h00};
          txcnt_next   = txcnt_reg + 4'd1;
        end
      end
      WAIT: begin
`ifdef FP_MULT_HOST_TIMEOUT_EN
        to_cnt_next = to_cnt_reg + 16'd1;
`endif
        if (RX_READY) begin
          res_sr_next = res_shift;
          rxcnt_next  = 4'd1;
          state_next  = RECV;
        end
      end
      RECV: begin
`ifdef FP_MULT_HOST_TIMEOUT_EN
        to_cnt_next = to_cnt_reg + 16'd1;
`endif
        if (RX_READY) begin
          if (rxcnt_reg == 4'(NBYTES_OP-1)) begin
            result_next = res_shift;
            done_next   = 1'b1;
            busy_next   = 1'b0;
            rxcnt_next  = 4'd0;
            state_next  = IDLE;
          end else begin
            res_sr_next = res_shift;
            rxcnt_next  = rxcnt_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef FP_MULT_HOST_TIMEOUT_EN
    // A completing final byte takes priority over a coincident timeout.
    if ((state_reg == WAIT || state_reg == RECV) && state_next != IDLE &&
        to_cnt_reg == 16'(TIMEOUT-1)) begin
      error_next = 1'b1;
      busy_next  = 1'b0;
      state_next = IDLE;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      op_sr_reg      <= '0;
      res_sr_reg     <= '0;
      txcnt_reg      <= 4'd0;
      rxcnt_reg      <= 4'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      core_reset_reg <= 1'b0;
      enable_reg     <= 1'b0;
      tx_data_reg    <= 8'h00;
      // An aborted transaction keeps the last completed product; reset from idle clears it.
      if (state_reg == IDLE)
        result_reg <= '0;
`ifdef FP_MULT_HOST_TIMEOUT_EN
      to_cnt_reg     <= 16'd0;
      error_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      op_sr_reg      <= op_sr_next;
      res_sr_reg     <= res_sr_next;
      result_reg     <= result_next;
      txcnt_reg      <= txcnt_next;
      rxcnt_reg      <= rxcnt_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      core_reset_reg <= core_reset_next;
      enable_reg     <= enable_next;
      tx_data_reg    <= tx_data_next;
`ifdef FP_MULT_HOST_TIMEOUT_EN
      to_cnt_reg     <= to_cnt_next;
      error_reg      <= error_next;
`endif
    end
  end

  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign RESULT     = result_reg;
  assign CORE_RESET = core_reset_reg;
  assign ENABLE     = enable_reg;
  assign TX_DATA    = tx_data_reg;
`ifdef FP_MULT_HOST_TIMEOUT_EN
  assign ERROR      = error_reg;
`endif

endmodule

// File: tb/tb_fp_mult_host.sv
// Self-checking bench for fp_mult_host: directed cases plus randomized transactions with a byte-level responder model.
module tb_fp_mult_host;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [63:0] OP_A, OP_B;
  logic        BUSY, DONE;
  logic [63:0] RESULT;
`ifdef FP_MULT_HOST_TIMEOUT_EN
  logic        ERROR;
`endif
  logic        CORE_RESET, ENABLE;
  logic [7:0]  TX_DATA;
  logic [7:0]  RX_DATA;
  logic        RX_READY;

  int n_checks = 0;
  int n_err = 0;
  logic [63:0] last_result = 64'h0;

  always #5 CLK = ~CLK;

`ifdef FP_MULT_HOST_TIMEOUT_EN
  fp_mult_host #(.NBYTES_OP(8), .TIMEOUT(20)) u_dut (
`else
  fp_mult_host #(.NBYTES_OP(8)) u_dut (
`endif
    .CLK(CLK), .RESET(RESET), .START(START), .OP_A(OP_A), .OP_B(OP_B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
`ifdef FP_MULT_HOST_TIMEOUT_EN
    .ERROR(ERROR),
`endif
    .CORE_RESET(CORE_RESET), .ENABLE(ENABLE), .TX_DATA(TX_DATA),
    .RX_DATA(RX_DATA), .RX_READY(RX_READY)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; START is driven immediately. Returns at the DONE cycle
  // (or first WAIT cycle when reply=0, or after a mid-stream reset when rst_at>=0).
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] prod,
                         input int stall_max, input int stall_at, input int extra,
                         input int inj_at, input int rst_at, input bit reply);
    logic [127:0] ops;
    bit stray;
    int st;
    ops = {a, b};
    stray = 1'b0;
    START = 1'b1; OP_A = a; OP_B = b;
    @(negedge CLK);
    START = 1'b0; OP_A = rand64(); OP_B = rand64();
    chk("core_reset_pulse", 64'(CORE_RESET), 64'd1);
    chk("busy_after_start", 64'(BUSY), 64'd1);
    chk("enable_in_crst", 64'(ENABLE), 64'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("enable_send", 64'(ENABLE), 64'd1);
      chk($sformatf("tx_byte%0d", i), 64'(TX_DATA), 64'(8'(ops >> (8 * (15 - i)))));
      if (CORE_RESET) stray = 1'b1;
      RX_READY = 1'($urandom_range(0, 1));
      RX_DATA  = 8'($urandom);
      if (i == inj_at) begin
        START = 1'b1; OP_A = 64'h1;
      end
      if (i == rst_at) begin
        RESET = 1'b1; RX_READY = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        chk("enable_after_rst", 64'(ENABLE), 64'd0);
        chk("busy_after_rst", 64'(BUSY), 64'd0);
        chk("result_after_rst", RESULT, last_result);
        return;
      end
    end
    chk("core_reset_single", 64'(stray), 64'd0);
    @(negedge CLK);
    START = 1'b0;
    RX_READY = 1'b0;
    chk("enable_wait", 64'(ENABLE), 64'd0);
    chk("tx_data_wait", 64'(TX_DATA), 64'd0);
    if (!reply) return;
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      st = (k == stall_at) ? 3 : int'($urandom_range(0, stall_max));
      for (int s = 0; s < st; s++) begin
        RX_READY = 1'b0; RX_DATA = 8'($urandom);
        @(negedge CLK);
        if (DONE) stray = 1'b1;
      end
      RX_READY = 1'b1; RX_DATA = 8'(prod >> (8 * (7 - k)));
      @(negedge CLK);
      if (k < 7 && DONE) stray = 1'b1;
    end
    RX_READY = 1'b0;
    chk("done_pulse", 64'(DONE), 64'd1);
    chk("busy_at_done", 64'(BUSY), 64'd0);
    chk("result", RESULT, prod);
    chk("no_early_done", 64'(stray), 64'd0);
    last_result = prod;
    if (extra > 0) begin
      stray = 1'b0;
      for (int e = 0; e < extra; e++) begin
        RX_READY = 1'b1; RX_DATA = 8'($urandom);
        @(negedge CLK);
        if (DONE || BUSY || CORE_RESET) stray = 1'b1;
      end
      RX_READY = 1'b0;
      chk("extra_bytes_ignored", 64'(stray), 64'd0);
      chk("result_hold", RESULT, prod);
    end
  endtask

  task automatic idle_check(input string tag, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (BUSY || CORE_RESET || DONE) bad = 1'b1;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic hang_test();
    run_txn(rand64(), rand64(), 64'h0, 0, -1, 0, -1, -1, 1'b0);
`ifdef FP_MULT_HOST_TIMEOUT_EN
    begin
      int j;
      bit early_done;
      j = 0;
      early_done = 1'b0;
      while (!ERROR && j < 1000) begin
        @(negedge CLK);
        if (DONE) early_done = 1'b1;
        j++;
      end
      chk("timeout_cycles", 64'(j), 64'd20);
      chk("done_on_timeout", 64'(early_done | DONE), 64'd0);
      chk("busy_on_timeout", 64'(BUSY), 64'd0);
      chk("result_on_timeout", RESULT, last_result);
      @(negedge CLK);
      chk("error_one_cycle", 64'(ERROR), 64'd0);
    end
`else
    begin
      bit dropped;
      dropped = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge CLK);
        if (!BUSY || DONE) dropped = 1'b1;
      end
      chk("busy_hold_1000", 64'(dropped), 64'd0);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("busy_after_hang_rst", 64'(BUSY), 64'd0);
      chk("result_after_hang_rst", RESULT, last_result);
    end
`endif
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; OP_A = 64'h0; OP_B = 64'h0;
    RX_DATA = 8'h00; RX_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_core_reset", 64'(CORE_RESET), 64'd0);
    chk("rst_enable", 64'(ENABLE), 64'd0);
    chk("rst_tx_data", 64'(TX_DATA), 64'd0);
    chk("rst_result", RESULT, 64'd0);
`ifdef FP_MULT_HOST_TIMEOUT_EN
    chk("rst_error", 64'(ERROR), 64'd0);
`endif
    RESET = 1'b0;
    @(negedge CLK);

    // 1.0 * 2.0
    run_txn(64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 0, -1, 0, -1, -1, 1'b1);
    @(negedge CLK);
    // stall before byte 3, ten trailing READY cycles
    run_txn(rand64(), rand64(), 64'hC008000000000000, 0, 3, 10, -1, -1, 1'b1);
    @(negedge CLK);
    // START during SEND must not start a second transaction
    run_txn(rand64(), rand64(), rand64(), 1, -1, 0, 5, -1, 1'b1);
    idle_check("no_second_txn", 4);
    // START in the DONE cycle is accepted immediately
    run_txn(rand64(), rand64(), rand64(), 1, -1, 0, -1, -1, 1'b1);
    run_txn(rand64(), rand64(), rand64(), 1, -1, 0, -1, -1, 1'b1);
    @(negedge CLK);
    // reset at SEND byte 9 keeps prior result, next transaction completes
    run_txn(64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 0, -1, 0, -1, -1, 1'b1);
    @(negedge CLK);
    run_txn(rand64(), rand64(), rand64(), 0, -1, 0, -1, 9, 1'b1);
    @(negedge CLK);
    run_txn(rand64(), rand64(), rand64(), 2, -1, 0, -1, -1, 1'b1);
    @(negedge CLK);

    for (int n = 0; n < 20; n++) begin
      bit chain;
      int extra;
      chain = 1'($urandom_range(0, 1));
      extra = chain ? 0 : int'($urandom_range(0, 2));
      run_txn(rand64(), rand64(), rand64(), int'($urandom_range(0, 3)), -1, extra, -1, -1, 1'b1);
      if (!chain) @(negedge CLK);
    end
    @(negedge CLK);

    hang_test();
    @(negedge CLK);
    run_txn(rand64(), rand64(), rand64(), 1, -1, 0, -1, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
